// File: rtl/uivtc_multi_window_mover_if.sv
// Video bus between the DDR read FIFOs, the window mover and the output stage.
// master = mover side (drives timing and pixels), slave = consumer side.
interface uivtc_multi_window_mover_if #(
  parameter int CH_NUM = 4,
  parameter int DATA_W = 32
);
  logic [CH_NUM*DATA_W-1:0] I_rd_ddr_data;
  logic                     O_vtc_hs;
  logic                     O_vtc_vs;
  logic [CH_NUM-1:0]        O_vtc_win_de;
  logic                     O_vtc_data_valid;
  logic [DATA_W-1:0]        O_vtc_data;

  modport master (
    input  I_rd_ddr_data,
    output O_vtc_hs,
    output O_vtc_vs,
    output O_vtc_win_de,
    output O_vtc_data_valid,
    output O_vtc_data
  );

  modport slave (
    output I_rd_ddr_data,
    input  O_vtc_hs,
    input  O_vtc_vs,
    input  O_vtc_win_de,
    input  O_vtc_data_valid,
    input  O_vtc_data
  );
endinterface

// File: rtl/uivtc_multi_window_mover.sv
// Video timing, bouncing windows and priority pixel mux for CH_NUM channels.
// Define VTC_BORDER_EN to draw a 1-pixel border around every window.
module uivtc_multi_window_mover #(
  parameter int CH_NUM       = 4,
  parameter int DATA_W       = 32,
  parameter int H_ActiveSize = 1920,
  parameter int H_FrameSize  = 2200,
  parameter int H_SyncStart  = 2008,
  parameter int H_SyncEnd    = 2052,
  parameter int V_ActiveSize = 1080,
  parameter int V_FrameSize  = 1125,
  parameter int V_SyncStart  = 1084,
  parameter int V_SyncEnd    = 1089,
  parameter int WIN_W        = 640,
  parameter int WIN_H        = 360,
  parameter int STEP         = 1,
  parameter int FRAME_DIV    = 2,
  parameter logic [95:0] INIT_X =
    96'({12'd640, 12'd0, 12'd640, 12'd0}),
  parameter logic [95:0] INIT_Y =
    96'({12'd360, 12'd360, 12'd0, 12'd0}),
  parameter logic [15:0] INIT_DIR =
    16'(8'b00_01_10_11)
) (
  input  logic I_vtc_clk,
  input  logic I_vtc_rst,
  input  logic I_video_move_en,
  uivtc_multi_window_mover_if.master vtc
);

  localparam logic [11:0] HF_M1 = 12'(H_FrameSize - 1);
  localparam logic [11:0] VF_M1 = 12'(V_FrameSize - 1);
  localparam logic [11:0] HSS   = 12'(H_SyncStart);
  localparam logic [11:0] HSE   = 12'(H_SyncEnd);
  localparam logic [11:0] VSS   = 12'(V_SyncStart);
  localparam logic [11:0] VSE   = 12'(V_SyncEnd);
  localparam logic [11:0] HAS   = 12'(H_ActiveSize);
  localparam logic [11:0] VAS   = 12'(V_ActiveSize);
  localparam logic [12:0] XMAX  = 13'(H_ActiveSize - WIN_W);
  localparam logic [12:0] YMAX  = 13'(V_ActiveSize - WIN_H);
  localparam logic [12:0] STP   = 13'(STEP);
  localparam logic [12:0] WW    = 13'(WIN_W);
  localparam logic [12:0] WH    = 13'(WIN_H);
  localparam logic [7:0]  DIV_M1 = 8'(FRAME_DIV - 1);

  logic [11:0]       r_hcnt;
  logic [11:0]       r_vcnt;
  logic [11:0]       r_x [CH_NUM];
  logic [11:0]       r_y [CH_NUM];
  logic [CH_NUM-1:0] r_h;
  logic [CH_NUM-1:0] r_v;
  logic [7:0]        r_div;
  logic              r_hs;
  logic              r_vs;
  logic              r_act;
  logic [CH_NUM-1:0] r_de;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  logic              w_tick;
  logic              w_upd;
  logic              w_hs;
  logic              w_vs;
  logic              w_act;
  logic [CH_NUM-1:0] w_de;
  logic [DATA_W-1:0] w_pix;

  // Returns {new_dir, new_pos}; clamps at 0 and pmax and flips direction.
  function automatic logic [12:0] f_step(
    input logic [11:0] p,
    input logic        d,
    input logic [12:0] pmax
  );
    logic [12:0] w_sum;
    w_sum = {1'b0, p} + STP;
    if (d)
      f_step = (w_sum >= pmax) ? {1'b0, pmax[11:0]}
                               : {1'b1, w_sum[11:0]};
    else
      f_step = ({1'b0, p} <= STP) ? {1'b1, 12'd0}
                                  : {1'b0, p - STP[11:0]};
  endfunction

  always_ff @(posedge I_vtc_clk) begin
    if (I_vtc_rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (r_hcnt == HF_M1) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == VF_M1) ? '0 : r_vcnt + 12'd1;
    end else begin
      r_hcnt <= r_hcnt + 12'd1;
    end
  end

  // Tick sits at the start of vertical blank, so moves never tear a frame.
  assign w_tick = (r_hcnt == 12'd0) && (r_vcnt == VAS);
  assign w_upd  = w_tick && (r_div == DIV_M1);

  always_ff @(posedge I_vtc_clk) begin
    if (I_vtc_rst || !I_video_move_en) begin
      r_div <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        r_x[i] <= INIT_X[i*12 +: 12];
        r_y[i] <= INIT_Y[i*12 +: 12];
        r_h[i] <= INIT_DIR[2*i+1];
        r_v[i] <= INIT_DIR[2*i];
      end
    end else if (w_tick) begin
      r_div <= w_upd ? 8'd0 : r_div + 8'd1;
      if (w_upd) begin
        for (int i = 0; i < CH_NUM; i++) begin
          {r_h[i], r_x[i]} <= f_step(r_x[i], r_h[i], XMAX);
          {r_v[i], r_y[i]} <= f_step(r_y[i], r_v[i], YMAX);
        end
      end
    end
  end

  assign w_hs  = (r_hcnt >= HSS) && (r_hcnt < HSE);
  assign w_vs  = (r_vcnt >= VSS) && (r_vcnt < VSE);
  assign w_act = (r_hcnt < HAS) && (r_vcnt < VAS);

  always_comb begin
    w_de = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      w_de[i] = ({1'b0, r_hcnt} >= {1'b0, r_x[i]}) &&
                ({1'b0, r_hcnt} <  {1'b0, r_x[i]} + WW) &&
                ({1'b0, r_vcnt} >= {1'b0, r_y[i]}) &&
                ({1'b0, r_vcnt} <  {1'b0, r_y[i]} + WH);
    end
  end

  always_ff @(posedge I_vtc_clk) begin
    if (I_vtc_rst) begin
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      r_act <= 1'b0;
      r_de  <= '0;
    end else begin
      r_hs  <= w_hs;
      r_vs  <= w_vs;
      r_act <= w_act;
      r_de  <= w_de;
    end
  end

`ifdef VTC_BORDER_EN
  localparam logic [DATA_W-1:0] BORDER_COLOR = DATA_W'(32'h00FF_FFFF);

  logic [CH_NUM-1:0] w_bdr;
  logic [CH_NUM-1:0] r_bdr;

  always_comb begin
    w_bdr = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      w_bdr[i] = w_de[i] && (
        (r_hcnt == r_x[i]) ||
        ({1'b0, r_hcnt} == {1'b0, r_x[i]} + WW - 13'd1) ||
        (r_vcnt == r_y[i]) ||
        ({1'b0, r_vcnt} == {1'b0, r_y[i]} + WH - 13'd1));
    end
  end

  always_ff @(posedge I_vtc_clk) begin
    if (I_vtc_rst) r_bdr <= '0;
    else           r_bdr <= w_bdr;
  end

  always_comb begin
    w_pix = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (r_de[i])
        w_pix = r_bdr[i] ? BORDER_COLOR
                         : vtc.I_rd_ddr_data[i*DATA_W +: DATA_W];
    end
  end
`else
  // Ascending scan: the last (highest) enabled channel wins.
  always_comb begin
    w_pix = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (r_de[i])
        w_pix = vtc.I_rd_ddr_data[i*DATA_W +: DATA_W];
    end
  end
`endif

  always_ff @(posedge I_vtc_clk) begin
    if (I_vtc_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= r_act;
      r_data  <= w_pix;
    end
  end

  assign vtc.O_vtc_hs         = r_hs;
  assign vtc.O_vtc_vs         = r_vs;
  assign vtc.O_vtc_win_de     = r_de;
  assign vtc.O_vtc_data_valid = r_valid;
  assign vtc.O_vtc_data       = r_data;

endmodule

// File: tb/tb_uivtc_multi_window_mover.sv
// Directed bench for uivtc_multi_window_mover on a shrunken 16x12 raster.
// A second 1-channel instance covers STEP=7 clamping and a zero-range axis.
module tb_uivtc_multi_window_mover;

  localparam int HF = 24;
  localparam int VF = 15;
  localparam logic [31:0] D0 = 32'h0000_AAAA;
  localparam logic [31:0] D1 = 32'h1111_0001;
  localparam logic [31:0] D2 = 32'h2222_0002;
  localparam logic [31:0] D3 = 32'h3333_0003;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic men = 1'b0;

  int tests = 0;
  int fails = 0;
  int m_h = 0, m_v = 0, p_h = 0, p_v = 0, q_h = 0, q_v = 0;
  int cyc, des;
  logic pv;

  always #5 clk = ~clk;

  uivtc_multi_window_mover_if #(.CH_NUM(4), .DATA_W(32)) bus1 ();
  uivtc_multi_window_mover_if #(.CH_NUM(1), .DATA_W(32)) bus2 ();

  assign bus1.I_rd_ddr_data = {D3, D2, D1, D0};
  assign bus2.I_rd_ddr_data = 32'h5;

  uivtc_multi_window_mover #(
    .CH_NUM(4), .DATA_W(32),
    .H_ActiveSize(16), .H_FrameSize(HF),
    .H_SyncStart(18), .H_SyncEnd(20),
    .V_ActiveSize(12), .V_FrameSize(VF),
    .V_SyncStart(13), .V_SyncEnd(14),
    .WIN_W(8), .WIN_H(6), .STEP(1), .FRAME_DIV(2),
    .INIT_X(96'({12'd8, 12'd0, 12'd8, 12'd0})),
    .INIT_Y(96'({12'd6, 12'd6, 12'd0, 12'd0})),
    .INIT_DIR(16'(8'b00_01_10_11))
  ) dut (
    .I_vtc_clk(clk),
    .I_vtc_rst(rst),
    .I_video_move_en(men),
    .vtc(bus1)
  );

  uivtc_multi_window_mover #(
    .CH_NUM(1), .DATA_W(32),
    .H_ActiveSize(16), .H_FrameSize(HF),
    .H_SyncStart(18), .H_SyncEnd(20),
    .V_ActiveSize(12), .V_FrameSize(VF),
    .V_SyncStart(13), .V_SyncEnd(14),
    .WIN_W(8), .WIN_H(12), .STEP(7), .FRAME_DIV(1),
    .INIT_X(96'd6), .INIT_Y(96'd0),
    .INIT_DIR(16'b11)
  ) dut2 (
    .I_vtc_clk(clk),
    .I_vtc_rst(rst),
    .I_video_move_en(men),
    .vtc(bus2)
  );

  // Raster model: m = counters now, p = one clock ago, q = two clocks ago.
  always @(posedge clk) begin
    if (rst) begin
      m_h <= 0;
      m_v <= 0;
    end else if (m_h == HF-1) begin
      m_h <= 0;
      m_v <= (m_v == VF-1) ? 0 : m_v + 1;
    end else begin
      m_h <= m_h + 1;
    end
    p_h <= m_h; p_v <= m_v;
    q_h <= p_h; q_v <= p_v;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the negedge where stage-lat outputs reflect pixel (h,v).
  task automatic goto(input int h, input int v, input int lat);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 2*HF*VF && !hit; n++) begin
      @(negedge clk);
      hit = (lat == 1) ? (p_h == h && p_v == v)
                       : (q_h == h && q_v == v);
    end
    tests++;
    assert (hit === 1'b1) else begin
      fails++;
      $error("FAIL goto_%0d_%0d: observed 0 expected 1", h, v);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hs"}, bus1.O_vtc_hs, 0);
    chk({tag, "_vs"}, bus1.O_vtc_vs, 0);
    chk({tag, "_de"}, bus1.O_vtc_win_de, 0);
    chk({tag, "_valid"}, bus1.O_vtc_data_valid, 0);
    chk({tag, "_data"}, bus1.O_vtc_data, 0);
    chk({tag, "_de2"}, bus2.O_vtc_win_de, 0);
  endtask

  initial begin
    rst = 1'b1;
    men = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;

    goto(17, 0, 1); chk("hs17", bus1.O_vtc_hs, 0);
    goto(18, 0, 1); chk("hs18", bus1.O_vtc_hs, 1);
    goto(19, 0, 1); chk("hs19", bus1.O_vtc_hs, 1);
    goto(20, 0, 1); chk("hs20", bus1.O_vtc_hs, 0);
    goto(23, 12, 1); chk("vs12", bus1.O_vtc_vs, 0);
    goto(0, 13, 1); chk("vs13", bus1.O_vtc_vs, 1);

    cyc = 0; des = 0; pv = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      cyc++;
      des += int'(bus1.O_vtc_win_de[0]);
      if (bus1.O_vtc_vs && !pv) break;
      pv = bus1.O_vtc_vs;
    end
    chk("vs_period", cyc, 360);
    chk("de0_per_frame", des, 48);
    goto(0, 14, 1); chk("vs14", bus1.O_vtc_vs, 0);

    goto(0, 0, 1);
    chk("valid_lat1", bus1.O_vtc_data_valid, 0);
    chk("de0_origin", bus1.O_vtc_win_de[0], 1);
    goto(0, 0, 2);
    chk("valid_lat2", bus1.O_vtc_data_valid, 1);
    chk("data_0_0", bus1.O_vtc_data, D0);
    goto(15, 0, 2);
    chk("valid_15", bus1.O_vtc_data_valid, 1);
    chk("data_15_0", bus1.O_vtc_data, D1);
    goto(16, 0, 2);
    chk("valid_16", bus1.O_vtc_data_valid, 0);
    chk("data_16_0", bus1.O_vtc_data, 0);
    goto(9, 1, 2); chk("data_9_1", bus1.O_vtc_data, D1);
    goto(1, 7, 2); chk("data_1_7", bus1.O_vtc_data, D2);
    goto(12, 8, 2); chk("data_12_8", bus1.O_vtc_data, D3);

    men = 1'b1;
    goto(1, 12, 1);
    goto(0, 0, 1); chk("b_ch0_hold", bus1.O_vtc_win_de[0], 1);
    goto(7, 0, 1); chk("b_d2_7", bus2.O_vtc_win_de[0], 0);
    goto(8, 0, 1); chk("b_d2_clamp", bus2.O_vtc_win_de[0], 1);
    goto(1, 12, 1);

    goto(0, 0, 1); chk("c_d2_0", bus2.O_vtc_win_de[0], 0);
    goto(1, 0, 1);
    chk("c_ch0_1_0", bus1.O_vtc_win_de[0], 0);
    chk("c_d2_back", bus2.O_vtc_win_de[0], 1);
    goto(0, 1, 1); chk("c_ch0_0_1", bus1.O_vtc_win_de[0], 0);
    goto(1, 1, 1); chk("c_ch0_1_1", bus1.O_vtc_win_de[0], 1);
    goto(6, 5, 1); chk("c_ch3_6_5", bus1.O_vtc_win_de[3], 0);
    goto(7, 5, 1); chk("c_ch3_7_5", bus1.O_vtc_win_de[3], 1);
    goto(1, 11, 1); chk("c_d2_ymax0", bus2.O_vtc_win_de[0], 1);
    goto(1, 12, 1);
    goto(1, 12, 1);

    goto(6, 0, 1); chk("e_d2_6", bus2.O_vtc_win_de[0], 0);
    goto(7, 0, 1); chk("e_d2_7", bus2.O_vtc_win_de[0], 1);
    goto(6, 1, 1); chk("e_ch1_6_1", bus1.O_vtc_win_de[1], 0);
    goto(7, 1, 1); chk("e_ch1_7_1", bus1.O_vtc_win_de[1], 1);
    goto(14, 1, 1); chk("e_ch1_14_1", bus1.O_vtc_win_de[1], 1);
    goto(15, 1, 1); chk("e_ch1_15_1", bus1.O_vtc_win_de[1], 0);
    goto(1, 2, 1); chk("e_ch0_1_2", bus1.O_vtc_win_de[0], 0);
    goto(2, 2, 1); chk("e_ch0_2_2", bus1.O_vtc_win_de[0], 1);
    goto(7, 2, 2); chk("e_data_7_2", bus1.O_vtc_data, D1);
    goto(3, 3, 2); chk("e_data_3_3", bus1.O_vtc_data, D0);
    goto(5, 4, 1); chk("e_ch3_5_4", bus1.O_vtc_win_de[3], 0);
    goto(6, 4, 1); chk("e_ch3_6_4", bus1.O_vtc_win_de[3], 1);
    goto(6, 4, 2); chk("e_overlap", bus1.O_vtc_data, D3);

    men = 1'b0;
    goto(7, 6, 1); chk("off_ch3_7_6", bus1.O_vtc_win_de[3], 0);
    goto(8, 6, 1); chk("off_ch3_8_6", bus1.O_vtc_win_de[3], 1);
    goto(2, 7, 1); chk("off_ch0_2_7", bus1.O_vtc_win_de[0], 0);

    men = 1'b1;
    goto(1, 12, 1);
    goto(1, 12, 1);
    goto(0, 5, 1); chk("g_ch0_0_5", bus1.O_vtc_win_de[0], 0);
    goto(1, 5, 1); chk("g_ch0_1_5", bus1.O_vtc_win_de[0], 1);

    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    goto(0, 0, 1); chk("r_ch0_0_0", bus1.O_vtc_win_de[0], 1);
    goto(7, 6, 1); chk("r_ch3_7_6", bus1.O_vtc_win_de[3], 0);
    goto(8, 6, 1); chk("r_ch3_8_6", bus1.O_vtc_win_de[3], 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
